// File: rtl/mem_wait_responder.sv
// Latency-realistic byte memory answering the req/resp protocol of the memory interface unit.
// Requests are level-held; each accepted request completes with one mem_resp pulse.
module mem_wait_responder #(
    parameter int ADDR_W      = 14,
    parameter int DEPTH       = 16384,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [7:0]        rdata,
    output logic              mem_resp,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD,
        WR_LO,
        WR_HI,
        RESP,
        RELEASE
    } state_t;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_hi;
    logic [15:0]       wdata_q;
    logic              op_write;
    logic              accept;
    logic [7:0]        mem [DEPTH];

    assign accept  = (state == IDLE) && (re ^ we);
    assign addr_hi = addr_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (re && we) begin
                    state_next = RELEASE;
                end else if (re) begin
                    state_next = (WAIT_CYCLES == 0) ? RD : WAIT;
                end else if (we) begin
                    state_next = (WAIT_CYCLES == 0) ? WR_LO : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == CNT_LAST) begin
                    state_next = op_write ? WR_LO : RD;
                end
            end
            RD:      state_next = RESP;
            WR_LO:   state_next = WR_HI;
            WR_HI:   state_next = RESP;
            RESP:    state_next = RELEASE;
            // A request still held after completion must drop before another is taken.
            RELEASE: begin
                if (!re && !we) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_resp = (state == RESP);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            op_write <= 1'b0;
            rdata    <= 8'h00;
            err      <= 1'b0;
        end else begin
            err <= (state == IDLE) && re && we;
            if (accept) begin
                addr_q   <= addr;
                op_write <= we;
                wait_cnt <= '0;
                if (we) begin
                    wdata_q <= wdata;
                end
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state == RD) begin
                rdata <= mem[addr_q];
            end
        end
    end

    // The array has no reset; a reset between WR_LO and WR_HI leaves only the low byte written.
    always_ff @(posedge clk) begin
        if (state == WR_LO) begin
            mem[addr_q] <= wdata_q[7:0];
        end else if (state == WR_HI) begin
            mem[addr_hi] <= wdata_q[15:8];
        end
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Bench for mem_wait_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// share one request bus, steered by sel; expected rdata flows through a scoreboard queue.
module tb_mem_wait_responder;

    localparam int ADDR_W = 14;

    typedef struct {
        int                sel;
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
        logic [7:0]        exp_rd;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, rst_b;
    logic              re_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       wdata_d;
    int                sel;

    logic       re_a, we_a, re_b, we_b;
    logic [7:0] rdata_a, rdata_b, rdata_m;
    logic       resp_a, resp_b, resp_m;
    logic       busy_a, busy_b, busy_m;
    logic       err_a, err_b, err_m;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_rd[2];
    vec_t       vecs[11];

    assign re_a = (sel == 0) && re_d;
    assign we_a = (sel == 0) && we_d;
    assign re_b = (sel == 1) && re_d;
    assign we_b = (sel == 1) && we_d;

    always_comb begin
        rdata_m = (sel == 0) ? rdata_a : rdata_b;
        resp_m  = (sel == 0) ? resp_a  : resp_b;
        busy_m  = (sel == 0) ? busy_a  : busy_b;
        err_m   = (sel == 0) ? err_a   : err_b;
    end

    mem_wait_responder #(.ADDR_W(ADDR_W), .DEPTH(16384), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(rst_a), .re(re_a), .we(we_a), .addr(addr_d), .wdata(wdata_d),
        .rdata(rdata_a), .mem_resp(resp_a), .busy(busy_a), .err(err_a)
    );

    mem_wait_responder #(.ADDR_W(ADDR_W), .DEPTH(16384), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(rst_b), .re(re_b), .we(we_b), .addr(addr_d), .wdata(wdata_d),
        .rdata(rdata_b), .mem_resp(resp_b), .busy(busy_b), .err(err_b)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle 0 is the first cycle the request is high with the DUT in IDLE.
    task automatic apply_stimulus(input int s, input bit is_wr, input logic [ADDR_W-1:0] a,
                                  input logic [15:0] wd, input logic [7:0] exp_rd,
                                  input int hold_after);
        int         cyc;
        int         lat_exp;
        int         extra;
        bit         got;
        bit         busy_ok;
        logic [7:0] exp;
        lat_exp = ((s == 0) ? 2 : 0) + (is_wr ? 3 : 2);
        sel = s;
        @(posedge clk); #1;
        re_d    = !is_wr;
        we_d    = is_wr;
        addr_d  = a;
        wdata_d = wd;
        sb_q.push_back(is_wr ? last_rd[s] : exp_rd);
        cyc = 0; got = 0; busy_ok = 1;
        while (!got && cyc <= 40) begin
            @(negedge clk);
            if ((cyc == 0 && busy_m !== 1'b0) || (cyc > 0 && busy_m !== 1'b1)) busy_ok = 0;
            if (resp_m === 1'b1) begin
                got = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                if (cyc == 1) begin
                    addr_d  = ADDR_W'($urandom);
                    wdata_d = 16'($urandom);
                end
            end
        end
        exp = sb_q.pop_front();
        if (!got) begin
            check_output("resp_timeout", 32'd0, 32'd1);
        end else begin
            check_output(is_wr ? "write_latency" : "read_latency", 32'(cyc), 32'(lat_exp));
            check_output(is_wr ? "rdata_after_write" : "read_data", 32'(rdata_m), 32'(exp));
            if (!is_wr) last_rd[s] = exp_rd;
        end
        check_output("busy_profile", 32'(busy_ok), 32'd1);
        extra = 0;
        for (int i = 0; i < hold_after; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (resp_m === 1'b1) extra++;
        end
        if (hold_after > 0) check_output("held_resp_count", 32'(extra), 32'd0);
        @(posedge clk); #1;
        re_d = 1'b0;
        we_d = 1'b0;
    endtask

    initial begin
        int nresp;
        vecs[0]  = '{0, 1'b1, 14'h0010, 16'hBEEF, 8'h00};
        vecs[1]  = '{0, 1'b0, 14'h0010, 16'h0000, 8'hEF};
        vecs[2]  = '{0, 1'b0, 14'h0011, 16'h0000, 8'hBE};
        vecs[3]  = '{0, 1'b1, 14'h3FFF, 16'h1234, 8'h00};
        vecs[4]  = '{0, 1'b0, 14'h3FFF, 16'h0000, 8'h34};
        vecs[5]  = '{0, 1'b0, 14'h0000, 16'h0000, 8'h12};
        vecs[6]  = '{1, 1'b1, 14'h0020, 16'hC3A5, 8'h00};
        vecs[7]  = '{1, 1'b0, 14'h0020, 16'h0000, 8'hA5};
        vecs[8]  = '{1, 1'b0, 14'h0021, 16'h0000, 8'hC3};
        vecs[9]  = '{0, 1'b1, 14'h0100, 16'h7766, 8'h00};
        vecs[10] = '{0, 1'b0, 14'h0101, 16'h0000, 8'h77};
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        sel = 0; re_d = 0; we_d = 0; addr_d = '0; wdata_d = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_rdata_a", 32'(rdata_a), 32'h0);
        check_output("reset_resp_a",  32'(resp_a),  32'h0);
        check_output("reset_busy_a",  32'(busy_a),  32'h0);
        check_output("reset_err_a",   32'(err_a),   32'h0);
        check_output("reset_rdata_b", 32'(rdata_b), 32'h0);
        check_output("reset_busy_b",  32'(busy_b),  32'h0);
        rst_a = 1'b0; rst_b = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].sel, vecs[i].is_wr, vecs[i].addr, vecs[i].wdata,
                           vecs[i].exp_rd, 0);
        end

        // Simultaneous re and we: one-cycle err, no access, busy until both drop.
        sel = 0;
        nresp = 0;
        @(posedge clk); #1;
        re_d = 1'b1; we_d = 1'b1; addr_d = 14'h0010; wdata_d = 16'h0000;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (resp_m === 1'b1) nresp++;
            if (cyc == 1) check_output("err_pulse", 32'(err_m), 32'd1);
            if (cyc == 2) check_output("err_single_cycle", 32'(err_m), 32'd0);
            if (cyc == 3) check_output("err_busy_held", 32'(busy_m), 32'd1);
            if (cyc == 5) check_output("err_busy_released", 32'(busy_m), 32'd0);
            @(posedge clk); #1;
            if (cyc == 3) begin
                re_d = 1'b0; we_d = 1'b0;
            end
        end
        check_output("err_no_resp", 32'(nresp), 32'd0);
        apply_stimulus(0, 1'b0, 14'h0010, 16'h0000, 8'hEF, 0);

        // Read held long after completion, then re-requested after a one-cycle drop.
        apply_stimulus(0, 1'b0, 14'h3FFF, 16'h0000, 8'h34, 10);
        apply_stimulus(0, 1'b0, 14'h0000, 16'h0000, 8'h12, 0);

        // Reset lands while the high byte of a write is pending.
        sel = 0;
        @(posedge clk); #1;
        we_d = 1'b1; addr_d = 14'h0100; wdata_d = 16'hAA55;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check_output("pre_reset_busy", 32'(busy_a), 32'd1);
        #2;
        rst_a = 1'b1;
        #1;
        check_output("async_reset_busy",  32'(busy_a),  32'd0);
        check_output("async_reset_rdata", 32'(rdata_a), 32'h0);
        check_output("async_reset_resp",  32'(resp_a),  32'd0);
        @(posedge clk); #1;
        we_d = 1'b0; re_d = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        last_rd[0] = 8'h00;
        apply_stimulus(0, 1'b0, 14'h0100, 16'h0000, 8'h55, 0);
        apply_stimulus(0, 1'b0, 14'h0101, 16'h0000, 8'h77, 0);

        check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
